approx_add_pipe: RTL and testbench
==================================

// Module: approx_add_pipe
// PURPOSE
//  Parametrised, pipelined approximate unsigned adder; next generation of our fixed
//  8-bit lower-part-OR adders. Low APPROX_LSB bits are bitwise OR, with no carry out of
//  the low part. The upper carry chain is split into STAGES registered segments.
//  Adds per-transaction exact/approx mode, valid/ready flow control and an error-event
//  counter. Sits between operand producers and accelerator datapaths for accuracy/power
//  evaluation.
// PARAMETERS
//  WIDTH       8  operand width in bits (>=2)
//  APPROX_LSB  1  number of OR-approximated LSBs (0..WIDTH-1; 0 = always exact)
//  STAGES      2  pipeline depth = carry-chain segments (1..WIDTH-APPROX_LSB)
//  CNT_W       16 error-event counter width
// PORTS
//  clk        in   1        clock; all state changes on its rising edge
//  rst_n      in   1        synchronous reset, active-low
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        block can accept operand beat
//  in_a       in   WIDTH    operand A, unsigned
//  in_b       in   WIDTH    operand B, unsigned
//  in_exact   in   1        1: exact sum for this beat; 0: approximate
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_sum    out  WIDTH+1  result; MSB is carry-out
//  err_cnt    out  CNT_W    saturating count of accepted approx beats with nonzero error
//  cnt_clr    in   1        synchronous clear of err_cnt
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valids=0, out_valid=0, out_sum=0, err_cnt=0.
//    Reset mid-operation discards in-flight beats; in_ready=1 in the cycle after reset.
//  - Global-stall pipeline: adv = !out_valid | out_ready; in_ready = adv (combinational).
//    Accept when in_valid & in_ready. When adv=0, every stage holds data and valid.
//    Bubbles are not compressed. No combinational path from in_valid to out_valid.
//  - Latency: exactly STAGES cycles from accept to out_valid when out_ready stays 1.
//    Throughput is one beat per cycle. Ordering is preserved.
//  - Approx beat, with K=APPROX_LSB: sum[K-1:0] = a[K-1:0] | b[K-1:0].
//    sum[WIDTH:K] = a[WIDTH-1:K] + b[WIDTH-1:K], with carry-in 0.
//  - Exact beat: sum = a + b, full WIDTH+1 bit result (low part uses true add, carry into bit K).
//  - Segmenting: U=WIDTH-K upper bits; segment width S=ceil(U/STAGES), last segment takes
//    the remainder. Stage i computes segment i using the carry registered by stage i-1.
//    Stage 0 also resolves the low part and the mode. Unprocessed operand bits and in_exact
//    travel with the beat.
//  - Error event: accepted beat with in_exact=0 and (a[K-1:0] & b[K-1:0]) != 0.
//    This is exactly when the approx result differs from a+b. Counted at accept time.
//    err_cnt saturates at 2^CNT_W-1.
//  - cnt_clr: err_cnt <= 0, takes priority over an increment in the same cycle.
//    rst_n has priority over everything.
//  - K=0: the adder is always exact and err_cnt stays 0.
//    STAGES=1: single register stage, latency 1.
//  - out_sum holds its value while out_valid & !out_ready. It is don't-care when
//    out_valid=0; the bench checks it only on handshake.
// TESTING (defaults WIDTH=8, APPROX_LSB=1, STAGES=2, CNT_W=16)
//  1 Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, err_cnt=0, in_ready=1 after release.
//  2 a=1,b=1,exact=0 -> out_sum=1 two cycles later, err_cnt=1.
//    Same operands with exact=1 -> out_sum=2, err_cnt unchanged.
//  3 a=255,b=255: exact=0 -> 509 (0x1FD), err_cnt+1; exact=1 -> 510 (0x1FE).
//    a=254,b=1, exact=0 -> 255, no error event.
//  4 Back-to-back stream of 100 random beats with out_ready=1 -> one result per cycle,
//    in order, all matching the golden model.
//  5 Random out_ready backpressure (~50%) -> no beat lost or duplicated.
//    out_sum is stable while stalled; in_ready=0 exactly when out_valid & !out_ready.
//  6 Preload err_cnt near 0xFFFF -> it saturates at 0xFFFF.
//    cnt_clr together with an error beat -> 0. Mid-stream reset -> pending results dropped.

Source files
------------

// File: rtl/approx_add_pipe.sv
// Pipelined approximate unsigned adder.
// The low APPROX_LSB bits are ORed (approx beats) or truly added (exact beats).
// The upper carry chain is cut into STAGES registered segments, and the
// operands travel down the pipe alongside the partial sum.
// A single global stall (adv) freezes every stage when the output is blocked.
module approx_add_pipe #(
  parameter int WIDTH      = 8,
  parameter int APPROX_LSB = 1,
  parameter int STAGES     = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  localparam int K = APPROX_LSB;
  localparam int U = WIDTH - K;
  localparam int S = (U + STAGES - 1) / STAGES;

  // Per-stage pipeline registers (index = stage) and their next values.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic             x_q [STAGES];
  logic [WIDTH:0]   s_q [STAGES];
  logic             c_q [STAGES];

  logic             v_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic             x_d [STAGES];
  logic [WIDTH:0]   s_d [STAGES];
  logic             c_d [STAGES];

  logic             adv;
  logic             accept;
  logic             err_ev;
  logic [CNT_W-1:0] err_q;

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;
  assign err_cnt   = err_q;

  // Error event: an approx beat whose low parts overlap loses at least one carry.
  always_comb begin
    logic ov;
    ov = 1'b0;
    for (int j = 0; j < K; j++) begin
      ov = ov | (in_a[j] & in_b[j]);
    end
    err_ev = ov && !in_exact;
  end

  // Next-state of every stage: stage 0 resolves the low part, each stage adds its segment.
  always_comb begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             x;
    logic             c;
    logic [WIDTH:0]   s;
    logic [1:0]       t;
    int               lo;
    int               hi;
    for (int g = 0; g < STAGES; g++) begin
      lo = (g * S < U) ? g * S : U;
      hi = (g == STAGES - 1) ? U : (((g + 1) * S < U) ? (g + 1) * S : U);
      t  = 2'b00;
      if (g == 0) begin
        a = in_a;
        b = in_b;
        x = in_exact;
        c = 1'b0;
        s = '0;
        for (int j = 0; j < K; j++) begin
          if (x) begin
            t    = {1'b0, a[j]} + {1'b0, b[j]} + {1'b0, c};
            s[j] = t[0];
            c    = t[1];
          end else begin
            s[j] = a[j] | b[j];
          end
        end
        v_d[g] = in_valid;
      end else begin
        a      = a_q[g-1];
        b      = b_q[g-1];
        x      = x_q[g-1];
        c      = c_q[g-1];
        s      = s_q[g-1];
        v_d[g] = v_q[g-1];
      end
      for (int j = 0; j < U; j++) begin
        if (j >= lo && j < hi) begin
          t        = {1'b0, a[K+j]} + {1'b0, b[K+j]} + {1'b0, c};
          s[K+j]   = t[0];
          c        = t[1];
        end
      end
      if (g == STAGES - 1) begin
        s[WIDTH] = c;
      end
      a_d[g] = a;
      b_d[g] = b;
      x_d[g] = x;
      s_d[g] = s;
      c_d[g] = c;
    end
  end

  // Pipeline advance under global stall, plus the saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int g = 0; g < STAGES; g++) begin
        v_q[g] <= 1'b0;
        a_q[g] <= '0;
        b_q[g] <= '0;
        x_q[g] <= 1'b0;
        s_q[g] <= '0;
        c_q[g] <= 1'b0;
      end
      err_q <= '0;
    end else begin
      if (adv) begin
        for (int g = 0; g < STAGES; g++) begin
          v_q[g] <= v_d[g];
          a_q[g] <= a_d[g];
          b_q[g] <= b_d[g];
          x_q[g] <= x_d[g];
          s_q[g] <= s_d[g];
          c_q[g] <= c_d[g];
        end
      end
      if (cnt_clr) begin
        err_q <= '0;
      end else if (accept && err_ev && (err_q != {CNT_W{1'b1}})) begin
        err_q <= err_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe with default parameters: directed corner cases,
// random streams and backpressure against an arithmetic reference model.
module tb_approx_add_pipe;

  localparam int WIDTH  = 8;
  localparam int K      = 1;
  localparam int STAGES = 2;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_exact = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH:0]   out_sum;
  logic [CNT_W-1:0] err_cnt;
  logic             cnt_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int out_cnt = 0;
  bit mon_en = 0;
  bit prev_stall = 0;
  logic [WIDTH:0]   prev_sum;
  logic [CNT_W-1:0] model_err = '0;
  logic [WIDTH:0]   sb[$];

  approx_add_pipe #(.WIDTH(WIDTH), .APPROX_LSB(K), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, b, input logic x);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (x) return (WIDTH+1)'(ia + ib);
    return (WIDTH+1)'((((ia >> K) + (ib >> K)) << K) | ((ia | ib) & ((1 << K) - 1)));
  endfunction

  function automatic bit ref_err(input logic [WIDTH-1:0] a, b, input logic x);
    return !x && ((int'(a) & int'(b) & ((1 << K) - 1)) != 0);
  endfunction

  // Scoreboard monitor: results, error count, stall stability, ready relation.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (err_cnt !== model_err) begin
        n_bad++;
        $display("FAIL mon_err_cnt: got %0h expected %0h at cycle %0d", err_cnt, model_err, cyc);
      end
      if (!rst_n) begin
        sb.delete();
        model_err = '0;
        prev_stall = 0;
      end else begin
        n_cmp++;
        if (in_ready !== !(out_valid && !out_ready)) begin
          n_bad++;
          $display("FAIL mon_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
        end
        if (prev_stall) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_sum !== prev_sum) begin
            n_bad++;
            $display("FAIL mon_stall_hold: got valid=%b sum=%0d expected valid=1 sum=%0d", out_valid, out_sum, prev_sum);
          end
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL mon_unexpected_out: got sum=%0d expected no result", out_sum);
          end else begin
            logic [WIDTH:0] exp_s;
            exp_s = sb.pop_front();
            if (out_sum !== exp_s) begin
              n_bad++;
              $display("FAIL mon_out_sum: got %0d expected %0d", out_sum, exp_s);
            end
          end
          out_cnt++;
        end
        if (in_valid && in_ready) sb.push_back(ref_sum(in_a, in_b, in_exact));
        if (cnt_clr) model_err = '0;
        else if (in_valid && in_ready && ref_err(in_a, in_b, in_exact) && model_err != '1)
          model_err = model_err + 1'b1;
        prev_stall = out_valid && !out_ready;
        prev_sum = out_sum;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] a, b, input logic x);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_exact = x;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL push_timeout: in_ready got 0 expected 1 within 200 cycles");
    end
  endtask

  // Send one beat on an idle pipe and check latency, sum and error count.
  task automatic single_beat(input logic [WIDTH-1:0] a, b, input logic x,
                             input logic [WIDTH:0] exp_sum, input logic [CNT_W-1:0] exp_err);
    int lat;
    lat = 0;
    push(a, b, x);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    n_cmp++;
    if (lat != STAGES) begin
      n_bad++;
      $display("FAIL latency a=%0d b=%0d: got %0d expected %0d", a, b, lat, STAGES);
    end
    n_cmp++;
    if (out_sum !== exp_sum) begin
      n_bad++;
      $display("FAIL sum a=%0d b=%0d exact=%b: got %0d expected %0d", a, b, x, out_sum, exp_sum);
    end
    n_cmp++;
    if (err_cnt !== exp_err) begin
      n_bad++;
      $display("FAIL err_cnt a=%0d b=%0d: got %0d expected %0d", a, b, err_cnt, exp_err);
    end
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 8'd3;
    in_b = 8'd1;
    tick(3);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || err_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b err=%0d expected valid=0 err=0", out_valid, err_cnt);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    mon_en = 1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tick(1);
  endtask

  task automatic test_basic();
    single_beat(8'd1, 8'd1, 1'b0, 9'd1, 16'd1);
    single_beat(8'd1, 8'd1, 1'b1, 9'd2, 16'd1);
  endtask

  task automatic test_corners();
    single_beat(8'd255, 8'd255, 1'b0, 9'h1FD, 16'd2);
    single_beat(8'd255, 8'd255, 1'b1, 9'h1FE, 16'd2);
    single_beat(8'd254, 8'd1,   1'b0, 9'd255, 16'd2);
    single_beat(8'd0,   8'd0,   1'b0, 9'd0,   16'd2);
  endtask

  task automatic test_back_to_back();
    int start, first_out;
    out_ready = 1'b1;
    start = cyc;
    first_out = out_cnt;
    for (int i = 0; i < 100; i++)
      push(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    n_cmp++;
    if (cyc - start != 100) begin
      n_bad++;
      $display("FAIL b2b_throughput: got %0d cycles expected 100", cyc - start);
    end
    tick(STAGES + 2);
    n_cmp++;
    if (out_cnt - first_out != 100 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results (%0d pending) expected 100 (0 pending)", out_cnt - first_out, sb.size());
    end
  endtask

  task automatic test_backpressure();
    bit done;
    int first_out;
    done = 0;
    first_out = out_cnt;
    fork
      begin
        for (int i = 0; i < 150; i++)
          push(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    tick(STAGES + 3);
    n_cmp++;
    if (out_cnt - first_out != 150 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL bp_count: got %0d results (%0d pending) expected 150 (0 pending)", out_cnt - first_out, sb.size());
    end
  endtask

  task automatic test_saturation();
    tick(STAGES + 1);
    dut.err_q = 16'hFFFD;
    model_err = 16'hFFFD;
    for (int i = 0; i < 3; i++) push(8'd3, 8'd1, 1'b0);
    tick(STAGES + 1);
    @(negedge clk);
    n_cmp++;
    if (err_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_err_cnt: got %0h expected ffff", err_cnt);
    end
    tick(1);
    cnt_clr = 1'b1;
    push(8'd1, 8'd1, 1'b0);
    cnt_clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL clr_priority: got %0h expected 0", err_cnt);
    end
    tick(STAGES + 1);
  endtask

  task automatic test_midreset();
    bit seen;
    seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 8'd10;
    in_b = 8'd20;
    in_exact = 1'b1;
    tick(1);
    in_a = 8'd7;
    in_b = 8'd9;
    in_exact = 1'b0;
    tick(1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL midreset_drop: got out_valid=1 expected 0 after reset");
    end
    tick(1);
    single_beat(8'd5, 8'd7, 1'b1, 9'd12, 16'd0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_midreset();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
